// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one run-of-ones detector across NCH serial channels.
// Per-channel run counters hold each channel's detector context; threshold writes force a clear pass.
module seq_det_sched #(
   parameter int NCH     = 4,
   parameter int CW      = 2,
   parameter int RW      = 3,
   parameter int RUN_LEN = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] req,
   input  logic [NCH-1:0] bit_in,
   input  logic [NCH-1:0] cfg_en,
   input  logic           cfg_we,
   input  logic [RW-1:0]  cfg_len,
   output logic [NCH-1:0] ack,
   output logic           hit,
   output logic [CW-1:0]  hit_ch,
   output logic           busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      EVAL  = 2'd2,
      CLEAR = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] ptr;
   logic [CW-1:0] sel;
   logic [CW-1:0] clr_idx;
   logic [CW-1:0] pick;
   logic [CW-1:0] cand;
   logic          found;
   logic [RW-1:0] cnt [NCH];
   logic [RW-1:0] len;
   logic [RW-1:0] pend_len;
   logic [RW-1:0] sat_cnt;
   logic [RW:0]   inc;
   logic          reach;
   logic          pend;
   logic          bit_cap;

   // A zero threshold would never be reachable, so it is promoted to 1.
   function automatic logic [RW-1:0] fix_len(input logic [RW-1:0] v);
      return (v == {RW{1'b0}}) ? {{(RW-1){1'b0}}, 1'b1} : v;
   endfunction

   // First enabled requester at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      cand  = ptr;
      for (int k = 0; k < NCH; k++) begin
         cand = ptr + CW'(k);
         if (!found && req[cand] && cfg_en[cand]) begin
            found = 1'b1;
            pick  = cand;
         end else begin
            pick = pick;
         end
      end
   end

   // Run increment evaluated one bit wider so the compare cannot wrap.
   always_comb begin
      inc     = {1'b0, cnt[sel]} + {{RW{1'b0}}, 1'b1};
      reach   = (inc >= {1'b0, len});
      sat_cnt = reach ? len : inc[RW-1:0];
   end

   // Scheduler state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= {CW{1'b0}};
         sel      <= {CW{1'b0}};
         clr_idx  <= {CW{1'b0}};
         len      <= RW'(RUN_LEN);
         pend_len <= {RW{1'b0}};
         pend     <= 1'b0;
         bit_cap  <= 1'b0;
         ack      <= {NCH{1'b0}};
         hit      <= 1'b0;
         hit_ch   <= {CW{1'b0}};
         busy     <= 1'b0;
         for (int i = 0; i < NCH; i++) cnt[i] <= {RW{1'b0}};
      end else begin
         ack <= {NCH{1'b0}};
         hit <= 1'b0;
         case (state)
            IDLE: begin
               if (pend || cfg_we) begin
                  len     <= cfg_we ? fix_len(cfg_len) : fix_len(pend_len);
                  pend    <= 1'b0;
                  clr_idx <= {CW{1'b0}};
                  busy    <= 1'b1;
                  state   <= CLEAR;
               end else if (found) begin
                  sel   <= pick;
                  ack   <= {{(NCH-1){1'b0}}, 1'b1} << pick;
                  busy  <= 1'b1;
                  state <= GRANT;
               end else begin
                  state <= IDLE;
               end
            end
            GRANT: begin
               bit_cap <= bit_in[sel];
               state   <= EVAL;
            end
            EVAL: begin
               if (cfg_en[sel]) begin
                  if (bit_cap) begin
                     cnt[sel] <= sat_cnt;
                     if (reach) begin
                        hit    <= 1'b1;
                        hit_ch <= sel;
                     end
                  end else begin
                     cnt[sel] <= {RW{1'b0}};
                  end
               end
               ptr   <= sel + {{(CW-1){1'b0}}, 1'b1};
               busy  <= 1'b0;
               state <= IDLE;
            end
            CLEAR: begin
               cnt[clr_idx] <= {RW{1'b0}};
               clr_idx      <= clr_idx + {{(CW-1){1'b0}}, 1'b1};
               if (clr_idx == CW'(NCH - 1)) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  state <= CLEAR;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
         // Writes that arrive while busy are parked until the next IDLE; last one wins.
         if (cfg_we && state != IDLE) begin
            pend     <= 1'b1;
            pend_len <= cfg_len;
         end
         for (int i = 0; i < NCH; i++) begin
            if (!cfg_en[i]) cnt[i] <= {RW{1'b0}};
         end
      end
   end

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: hand-derived vector table, directed corner sequences,
// and random stimulus against a run-length reference model.
module tb_seq_det_sched;
   localparam int NCH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000, bit_in = 4'b0000, cfg_en = 4'b0000;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_len = 3'd0;
   logic [3:0] ack;
   logic       hit;
   logic [1:0] hit_ch;
   logic       busy;

   always #5 clk = ~clk;

   seq_det_sched #(.NCH(4), .CW(2), .RW(3), .RUN_LEN(4)) dut (
      .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .cfg_en(cfg_en),
      .cfg_we(cfg_we), .cfg_len(cfg_len), .ack(ack), .hit(hit),
      .hit_ch(hit_ch), .busy(busy)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hits[NCH];

   // next-cycle drive values
   logic       d_rst = 1'b0, d_we = 1'b0;
   logic [3:0] d_req = 4'b0000, d_bit = 4'b0000, d_en = 4'b0001;
   logic [2:0] d_len = 3'd0;

   // reference model: phase of the shared detector plus integer run lengths
   bit model_on = 1'b0;
   int m_grant, m_sel, m_clear, m_ptr, m_hit_ch, m_len, m_plen;
   bit m_eval, m_pend, m_bit, m_hit;
   int run[NCH];

   typedef struct {
      logic [3:0] req;
      logic [3:0] bits;
      logic [3:0] en;
      logic [3:0] e_ack;
      logic       e_hit;
      logic [1:0] e_ch;
      logic       e_busy;
   } vec_t;
   vec_t tbl[22];

   bit p2[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int fix(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   task automatic model_reset();
      m_grant = -1; m_sel = 0; m_clear = 0; m_ptr = 0; m_hit_ch = 0;
      m_len = 4; m_plen = 0; m_eval = 1'b0; m_pend = 1'b0; m_bit = 1'b0; m_hit = 1'b0;
      for (int i = 0; i < NCH; i++) run[i] = 0;
   endtask

   task automatic model_step();
      bit exp_busy, idle;
      int ng, c, idx;
      exp_busy = (m_grant >= 0) || m_eval || (m_clear > 0);
      chk("m_ack", ack, (m_grant >= 0) ? (1 << m_grant) : 0);
      chk("m_busy", busy, exp_busy);
      chk("m_hit", hit, m_hit);
      chk("m_hit_ch", hit_ch, m_hit_ch);
      if (rst === 1'b1) begin
         model_reset();
         return;
      end
      m_hit = 1'b0;
      if (m_eval) begin
         c = m_sel;
         if (cfg_en[c]) begin
            if (m_bit) begin
               if (run[c] + 1 >= m_len) begin
                  m_hit = 1'b1;
                  m_hit_ch = c;
               end
               run[c] = (run[c] + 1 > m_len) ? m_len : run[c] + 1;
            end else begin
               run[c] = 0;
            end
         end
         m_ptr = (c + 1) % NCH;
      end
      idle = !exp_busy;
      if (m_clear > 0) m_clear--;
      ng = -1;
      if (idle) begin
         if (m_pend || cfg_we) begin
            m_len = cfg_we ? fix(int'(cfg_len)) : fix(m_plen);
            m_pend = 1'b0;
            m_clear = NCH;
            for (int i = 0; i < NCH; i++) run[i] = 0;
         end else begin
            for (int k = 0; k < NCH; k++) begin
               idx = (m_ptr + k) % NCH;
               if (ng < 0 && req[idx] && cfg_en[idx]) ng = idx;
            end
         end
      end else if (cfg_we) begin
         m_pend = 1'b1;
         m_plen = int'(cfg_len);
      end
      for (int i = 0; i < NCH; i++) if (!cfg_en[i]) run[i] = 0;
      if (m_grant >= 0) begin
         m_sel = m_grant;
         m_bit = bit_in[m_grant];
      end
      m_eval = (m_grant >= 0);
      m_grant = ng;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      rst = d_rst; req = d_req; bit_in = d_bit; cfg_en = d_en; cfg_we = d_we; cfg_len = d_len;
      @(negedge clk);
      if (model_on) model_step();
      if (hit === 1'b1 && !$isunknown(hit_ch)) hits[hit_ch]++;
      d_we = 1'b0;
      d_rst = 1'b0;
      cyc++;
   endtask

   task automatic idle(input int n);
      d_req = 4'b0000;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input int ch, input bit b);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         d_req = 4'b0001 << ch;
         d_bit = {4{b}};
         tick();
         if (ack[ch] === 1'b1) got = 1'b1;
      end
      d_req = 4'b0000;
      chk("send_ack", got, 1);
   endtask

   task automatic do_reset();
      d_rst = 1'b1;
      d_req = 4'b0000;
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int h0, h1, h2, h3, n1, n2, na;
      logic [3:0] acks[8];
      int ack_cyc[8];
      for (int i = 0; i < NCH; i++) hits[i] = 0;

      // ch0 run 1,1,1,1,1,0,1 from reset: grant every third cycle, hits after bits 4 and 5
      for (int c = 0; c < 22; c++) begin
         tbl[c].req    = 4'b0001;
         tbl[c].en     = 4'b0001;
         tbl[c].bits   = (c % 3 == 1) ? ((c == 16) ? 4'b0000 : 4'b0001) : 4'(c % 2);
         tbl[c].e_ack  = (c % 3 == 1) ? 4'b0001 : 4'b0000;
         tbl[c].e_busy = (c % 3 != 0);
         tbl[c].e_hit  = (c == 12 || c == 15);
         tbl[c].e_ch   = 2'd0;
      end

      d_rst = 1'b1; tick();
      d_rst = 1'b1; tick();
      model_reset();
      model_on = 1'b1;

      for (int c = 0; c < 22; c++) begin
         d_req = tbl[c].req; d_bit = tbl[c].bits; d_en = tbl[c].en;
         tick();
         chk($sformatf("tbl%0d_ack", c), ack, tbl[c].e_ack);
         chk($sformatf("tbl%0d_hit", c), hit, tbl[c].e_hit);
         chk($sformatf("tbl%0d_hit_ch", c), hit_ch, tbl[c].e_ch);
         chk($sformatf("tbl%0d_busy", c), busy, tbl[c].e_busy);
      end
      chk("p1_hits", hits[0], 2);
      // counter left at 1: three more ones reach the threshold
      h0 = hits[0];
      send(0, 1'b1); send(0, 1'b1);
      idle(3);
      chk("p1_tail_nohit", hits[0] - h0, 0);
      send(0, 1'b1);
      idle(3);
      chk("p1_tail_hit", hits[0] - h0, 1);

      // all channels requesting: strict rotation, 3 cycles apart
      do_reset();
      d_en = 4'b1111; d_req = 4'b1111; d_bit = 4'b0000;
      na = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (ack !== 4'b0000 && na < 8) begin
            acks[na] = ack;
            ack_cyc[na] = cyc;
            na++;
         end
      end
      chk("rr_count", na, 5);
      for (int k = 0; k < na && k < 5; k++) begin
         chk($sformatf("rr_ack%0d", k), acks[k], 4'b0001 << (k % 4));
         if (k > 0) chk($sformatf("rr_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 3);
      end

      // interleaved ch1 (all ones) and ch2 (1,1,0,1,1,1,1)
      do_reset();
      d_en = 4'b0110;
      h1 = hits[1]; h2 = hits[2]; n1 = 0; n2 = 0;
      for (int i = 0; i < 80 && n2 < 7; i++) begin
         d_req = 4'b0110;
         d_bit = {1'b0, p2[n2], 1'b1, 1'b0};
         tick();
         if (ack[1] === 1'b1) n1++;
         if (ack[2] === 1'b1) n2++;
      end
      idle(3);
      chk("il_n1", n1, 7);
      chk("il_n2", n2, 7);
      chk("il_hits1", hits[1] - h1, 4);
      chk("il_hits2", hits[2] - h2, 1);

      // threshold write during EVAL is parked, then a 4-cycle clear pass
      do_reset();
      d_en = 4'b1000;
      h3 = hits[3];
      send(3, 1'b1);
      d_we = 1'b1; d_len = 3'd2;
      tick();
      tick();
      chk("clr_idle_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("clr%0d_busy", i), busy, 1);
         chk($sformatf("clr%0d_ack", i), ack, 0);
      end
      tick();
      chk("clr_done_busy", busy, 0);
      send(3, 1'b1); send(3, 1'b1);
      idle(3);
      chk("len2_hits3", hits[3] - h3, 1);
      chk("len2_hit_ch", hit_ch, 3);

      // zero threshold behaves as one
      d_we = 1'b1; d_len = 3'd0;
      idle(6);
      d_en = 4'b0001;
      h0 = hits[0];
      send(0, 1'b1); send(0, 1'b0); send(0, 1'b1); send(0, 1'b1); send(0, 1'b0);
      idle(3);
      chk("len1_hits", hits[0] - h0, 3);

      // reset during EVAL discards the partial run
      do_reset();
      d_en = 4'b0001;
      send(0, 1'b1); send(0, 1'b1); send(0, 1'b1);
      d_rst = 1'b1;
      tick();
      tick();
      chk("rst_ack", ack, 0);
      chk("rst_hit", hit, 0);
      chk("rst_busy", busy, 0);
      h0 = hits[0];
      send(0, 1'b1); send(0, 1'b1); send(0, 1'b1);
      idle(3);
      chk("rst_three", hits[0] - h0, 0);
      send(0, 1'b1);
      idle(3);
      chk("rst_four", hits[0] - h0, 1);

      // disable in the EVAL cycle suppresses the hit
      do_reset();
      d_en = 4'b0001;
      h0 = hits[0];
      send(0, 1'b1); send(0, 1'b1); send(0, 1'b1); send(0, 1'b1);
      d_en = 4'b0000;
      tick();
      d_en = 4'b0001;
      idle(3);
      chk("dis_eval_hit", hits[0] - h0, 0);

      // random traffic against the model
      do_reset();
      d_en = 4'b1111;
      for (int i = 0; i < 3000; i++) begin
         d_req = 4'($urandom_range(0, 15));
         d_bit = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) d_en = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) begin
            d_we = 1'b1;
            d_len = 3'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 599) == 0) d_rst = 1'b1;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
